// File: rtl/exec_ctrl_pkg.sv
// Shared types and instruction-number constants for the ALU issue path.
package exec_ctrl_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 6;
  localparam int unsigned C16_W  = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } exec_state_t;

  typedef logic req_id_t;

  // Operand bundle handed to the execution element
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst_num;
    logic [C16_W-1:0]  const16;
    logic [DATA_W-1:0] const16_x;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
  } ee_ops_t;

  localparam logic [INST_W-1:0] ADD  = INST_W'(8);
  localparam logic [INST_W-1:0] ADDI = INST_W'(9);
  localparam logic [INST_W-1:0] SUB  = INST_W'(10);
  localparam logic [INST_W-1:0] LUI  = INST_W'(11);
  localparam logic [INST_W-1:0] AND  = INST_W'(20);
  localparam logic [INST_W-1:0] OR   = INST_W'(22);
  localparam logic [INST_W-1:0] XOR  = INST_W'(24);
  localparam logic [INST_W-1:0] NOR  = INST_W'(26);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module rr_arbiter2
  import exec_ctrl_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU execution element between the main (0) and auxiliary (1) issue slots,
// returning the result or a timeout error on a tagged valid/ready response channel.
module alu_issue_arbiter
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][PC_W-1:0]   req_pc,
  input  logic [1:0][INST_W-1:0] req_inst_num,
  input  logic [1:0][C16_W-1:0]  req_const16,
  input  logic [1:0][DATA_W-1:0] req_const16_x,
  input  logic [1:0][DATA_W-1:0] req_rs,
  input  logic [1:0][DATA_W-1:0] req_rt,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_id,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_timeout,
  output logic                   ee_start,
  input  logic                   ee_completed,
  output logic [PC_W-1:0]        ee_pc,
  output logic [INST_W-1:0]      ee_inst_num,
  output logic [C16_W-1:0]       ee_const16,
  output logic [DATA_W-1:0]      ee_const16_x,
  output logic [DATA_W-1:0]      ee_rs,
  output logic [DATA_W-1:0]      ee_rt,
  input  logic [DATA_W-1:0]      ee_out
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  exec_state_t      state;
  req_id_t          last;
  logic [CNT_W-1:0] cnt;
  ee_ops_t          ops;
  ee_ops_t          sel_ops;
  logic [1:0]       grant;
  req_id_t          gid;

  rr_arbiter2 u_arb (
    .valid (req_valid),
    .last  (last),
    .grant (grant)
  );

  assign gid       = grant[1];
  assign req_ready = (state == IDLE) ? grant : 2'b00;

  // Winner's request fields, captured on the IDLE handshake
  always_comb begin
    sel_ops           = '0;
    sel_ops.pc        = req_pc[gid];
    sel_ops.inst_num  = req_inst_num[gid];
    sel_ops.const16   = req_const16[gid];
    sel_ops.const16_x = req_const16_x[gid];
    sel_ops.rs        = req_rs[gid];
    sel_ops.rt        = req_rt[gid];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last         <= 1'b1;
      cnt          <= '0;
      ops          <= '0;
      ee_start     <= 1'b1;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            ops      <= sel_ops;
            resp_id  <= gid;
            last     <= gid;
            cnt      <= '0;
            ee_start <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // Completion takes precedence over the final timeout count
          if (ee_completed) begin
            resp_data    <= ee_out;
            resp_timeout <= 1'b0;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end else if (cnt == LAST_CNT) begin
            resp_data    <= '0;
            resp_timeout <= 1'b1;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            ee_start   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ee_pc        = ops.pc;
  assign ee_inst_num  = ops.inst_num;
  assign ee_const16   = ops.const16;
  assign ee_const16_x = ops.const16_x;
  assign ee_rs        = ops.rs;
  assign ee_rt        = ops.rt;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed vector table, multi-cycle sequences and a
// randomized phase checked against a transaction-level model with an ALU element stub.
module tb_alu_issue_arbiter;
  import exec_ctrl_pkg::*;

  localparam int T     = 15;
  localparam int NEVER = 1000;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_pc;
  logic [1:0][5:0]   req_inst_num;
  logic [1:0][15:0]  req_const16;
  logic [1:0][31:0]  req_const16_x;
  logic [1:0][31:0]  req_rs;
  logic [1:0][31:0]  req_rt;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [31:0]       resp_data;
  logic              resp_timeout;
  logic              ee_start;
  logic              ee_completed;
  logic [31:0]       ee_pc;
  logic [5:0]        ee_inst_num;
  logic [15:0]       ee_const16;
  logic [31:0]       ee_const16_x;
  logic [31:0]       ee_rs;
  logic [31:0]       ee_rt;
  logic [31:0]       ee_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_inst_num(req_inst_num), .req_const16(req_const16),
    .req_const16_x(req_const16_x), .req_rs(req_rs), .req_rt(req_rt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_timeout(resp_timeout),
    .ee_start(ee_start), .ee_completed(ee_completed),
    .ee_pc(ee_pc), .ee_inst_num(ee_inst_num), .ee_const16(ee_const16),
    .ee_const16_x(ee_const16_x), .ee_rs(ee_rs), .ee_rt(ee_rt), .ee_out(ee_out)
  );

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [15:0] c16,
                                          input logic [31:0] cx);
    case (op)
      ADD:     return rs + rt;
      ADDI:    return rs + cx;
      SUB:     return rs - rt;
      LUI:     return {c16, 16'h0000};
      AND:     return rs & rt;
      OR:      return rs | rt;
      XOR:     return rs ^ rt;
      NOR:     return ~(rs | rt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Element stub: cleared while ee_start is high, done ee_lat cycles after release
  int   ee_lat = NEVER;
  int   ee_cnt;
  logic ee_done;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ee_cnt  <= 0;
      ee_done <= 1'b0;
    end else if (ee_start) begin
      ee_cnt  <= 0;
      ee_done <= 1'b0;
    end else begin
      ee_cnt  <= ee_cnt + 1;
      ee_done <= (ee_cnt + 1 >= ee_lat);
    end
  end
  assign ee_completed = ee_done;
  assign ee_out       = alu_ref(ee_inst_num, ee_rs, ee_rt, ee_const16, ee_const16_x);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, " ee_start"}, 32'(ee_start), 32'd1);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, " resp_data"}, resp_data, 32'd0);
    chk({tag, " resp_timeout"}, 32'(resp_timeout), 32'd0);
    chk({tag, " ee ops"}, ee_pc | ee_rs | ee_rt | ee_const16_x | 32'(ee_const16) | 32'(ee_inst_num), 32'd0);
  endtask

  task automatic set_req(input logic id, input logic [31:0] pc, input logic [5:0] op,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] c16, input logic [31:0] cx);
    req_pc[id]        = pc;
    req_inst_num[id]  = op;
    req_rs[id]        = rs;
    req_rt[id]        = rt;
    req_const16[id]   = c16;
    req_const16_x[id] = cx;
  endtask

  typedef struct {
    logic        id;
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] c16;
    logic [31:0] cx;
    int          lat;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_to;
    int          exp_cyc;
  } vec_t;

  function automatic vec_t mk(input logic id, input logic [5:0] op, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [15:0] c16, input logic [31:0] cx,
                              input int lat, input int hold, input logic [31:0] ed,
                              input logic et, input int ec);
    vec_t v;
    v.id = id; v.op = op; v.rs = rs; v.rt = rt; v.c16 = c16; v.cx = cx;
    v.lat = lat; v.hold = hold; v.exp_data = ed; v.exp_to = et; v.exp_cyc = ec;
    return v;
  endfunction

  // Entered just after a negedge; returns just after the negedge following the response handshake
  task automatic run_vec(input int idx, input vec_t v);
    int n;
    logic [31:0] pc;
    pc = 32'h400 + 32'(idx * 4);
    set_req(v.id, pc, v.op, v.rs, v.rt, v.c16, v.cx);
    req_valid  = v.id ? 2'b10 : 2'b01;
    resp_ready = (v.hold == 0);
    ee_lat     = v.lat;
    #1;
    chk($sformatf("v%0d grant", idx), 32'(req_ready), v.id ? 32'd2 : 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    n = 1;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.exp_cyc));
    chk($sformatf("v%0d resp_id", idx), 32'(resp_id), 32'(v.id));
    chk($sformatf("v%0d resp_data", idx), resp_data, v.exp_data);
    chk($sformatf("v%0d resp_timeout", idx), 32'(resp_timeout), 32'(v.exp_to));
    chk($sformatf("v%0d ee_pc", idx), ee_pc, pc);
    chk($sformatf("v%0d ee_rs", idx), ee_rs, v.rs);
    chk($sformatf("v%0d ee_inst_num", idx), 32'(ee_inst_num), 32'(v.op));
    for (int k = 0; k < v.hold; k++) begin
      req_valid = 2'b11;
      #1;
      chk($sformatf("v%0d hold req_ready", idx), 32'(req_ready), 32'd0);
      chk($sformatf("v%0d hold resp_valid", idx), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d hold resp_data", idx), resp_data, v.exp_data);
      @(negedge clk);
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d resp drop", idx), 32'(resp_valid), 32'd0);
  endtask

  // Both requesters valid continuously; grants must alternate starting at 'first'
  task automatic run_pair(input logic first, input int n, input logic [31:0] d0, input logic [31:0] d1);
    int ng;
    int nr;
    logic g;
    ng = 0;
    nr = 0;
    resp_ready = 1'b1;
    ee_lat = 1;
    for (int c = 0; c < 100 && nr < n; c++) begin
      @(negedge clk);
      req_valid = (ng < n) ? 2'b11 : 2'b00;
      #1;
      if (req_ready != 2'b00) begin
        g = first ^ 1'(ng);
        chk($sformatf("pair grant %0d", ng), 32'(req_ready), g ? 32'd2 : 32'd1);
        ng++;
      end
      if (resp_valid) begin
        g = first ^ 1'(nr);
        chk($sformatf("pair resp_id %0d", nr), 32'(resp_id), 32'(g));
        chk($sformatf("pair resp_data %0d", nr), resp_data, g ? d1 : d0);
        nr++;
      end
    end
    chk("pair responses", 32'(nr), 32'(n));
    req_valid = 2'b00;
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last_id);
    int winner;
    if (v == 2'b00) return 2'b00;
    if (v == 2'b11) winner = last_id ? 0 : 1;
    else winner = v[1] ? 1 : 0;
    return 2'(1 << winner);
  endfunction

  vec_t tbl[10];
  logic [5:0] ops_tbl[9];

  initial begin
    logic saw;
    logic busy;
    logic lastp;
    logic exp_id;
    logic exp_to;
    logic [31:0] exp_d;
    logic [1:0] exp_rr;
    logic [1:0] taken;
    logic exp_rv;
    logic g;
    int hs_n;
    int exp_lat;
    int lat;
    int r;

    tbl[0] = mk(1'b0, ADD,   32'd5,          32'd7,          16'h0000, 32'h0,          1,     0, 32'd12,         1'b0, 3);
    tbl[1] = mk(1'b1, ADDI,  32'd100,        32'd0,          16'hFFFF, 32'hFFFF_FFFF,  2,     1, 32'd99,         1'b0, 4);
    tbl[2] = mk(1'b0, SUB,   32'd10,         32'd3,          16'h0000, 32'h0,          3,     0, 32'd7,          1'b0, 5);
    tbl[3] = mk(1'b1, LUI,   32'd0,          32'd0,          16'h1234, 32'h1234,       1,     5, 32'h1234_0000,  1'b0, 3);
    tbl[4] = mk(1'b0, AND,   32'hF0F0,       32'hFF00,       16'h0000, 32'h0,          4,     0, 32'h0000_F000,  1'b0, 6);
    tbl[5] = mk(1'b1, NOR,   32'd0,          32'd0,          16'h0000, 32'h0,          1,     0, 32'hFFFF_FFFF,  1'b0, 3);
    tbl[6] = mk(1'b0, ADD,   32'd1,          32'd2,          16'h0000, 32'h0,          NEVER, 2, 32'd0,          1'b1, 16);
    tbl[7] = mk(1'b1, XOR,   32'hAAAA_5555,  32'hFFFF_0000,  16'h0000, 32'h0,          14,    0, 32'h5555_5555,  1'b0, 16);
    tbl[8] = mk(1'b0, OR,    32'd1,          32'd2,          16'h0000, 32'h0,          15,    0, 32'd0,          1'b1, 16);
    tbl[9] = mk(1'b1, 6'd63, 32'd9,          32'd9,          16'h0000, 32'h0,          2,     0, 32'hDEAD_BEEF,  1'b0, 4);
    ops_tbl = '{ADD, ADDI, SUB, LUI, AND, OR, XOR, NOR, 6'd63};

    reset = 1'b0;
    req_valid = 2'b00;
    resp_ready = 1'b0;
    req_pc = '0; req_inst_num = '0; req_const16 = '0;
    req_const16_x = '0; req_rs = '0; req_rt = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset("por");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // Continuous contention: grants 0,1,0
    set_req(1'b0, 32'h500, SUB, 32'd10, 32'd3, 16'h0, 32'h0);
    set_req(1'b1, 32'h600, OR, 32'h0000_00F0, 32'h0000_000F, 16'h0, 32'h0);
    run_pair(1'b0, 3, 32'd7, 32'h0000_00FF);

    // Reset while requester 0's op is in WAIT; the op must vanish and the pointer reload
    @(negedge clk);
    set_req(1'b0, 32'h700, ADD, 32'd1, 32'd2, 16'h0, 32'h0);
    req_valid = 2'b01;
    resp_ready = 1'b1;
    ee_lat = NEVER;
    #1;
    chk("mid grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset("mid");
    @(negedge clk);
    reset = 1'b1;
    saw = 1'b0;
    repeat (T + 4) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    chk("no resp after reset", 32'(saw), 32'd0);
    set_req(1'b0, 32'h800, SUB, 32'd10, 32'd3, 16'h0, 32'h0);
    set_req(1'b1, 32'h900, XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 16'h0, 32'h0);
    run_pair(1'b0, 2, 32'd7, 32'hF00F_F00F);

    // Randomized traffic against a transaction-level model
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    busy = 1'b0;
    lastp = 1'b1;
    taken = 2'b00;
    hs_n = 0;
    exp_lat = 0;
    exp_id = 1'b0;
    exp_to = 1'b0;
    exp_d = '0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int q = 0; q < 2; q++) begin
        if (taken[q]) req_valid[q] = 1'b0;
        if (!req_valid[q] && $urandom_range(0, 2) == 0) begin
          set_req(1'(q), $urandom, ops_tbl[$urandom_range(0, 8)], $urandom, $urandom,
                  16'($urandom), $urandom);
          req_valid[q] = 1'b1;
        end
      end
      taken = 2'b00;
      resp_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rr = busy ? 2'b00 : model_grant(req_valid, lastp);
      chk("rnd req_ready", 32'(req_ready), 32'(exp_rr));
      exp_rv = busy && (n - hs_n >= exp_lat);
      chk("rnd resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv && resp_valid) begin
        chk("rnd resp_id", 32'(resp_id), 32'(exp_id));
        chk("rnd resp_data", resp_data, exp_d);
        chk("rnd resp_timeout", 32'(resp_timeout), 32'(exp_to));
        if (resp_ready) busy = 1'b0;
      end
      if (exp_rr != 2'b00) begin
        g = exp_rr[1];
        r = $urandom_range(0, 9);
        lat = (r <= 5) ? r + 1 : (r == 6) ? T - 2 : (r == 7) ? T - 1 : (r == 8) ? T : NEVER;
        ee_lat = lat;
        exp_lat = (lat + 2 < T + 1) ? lat + 2 : T + 1;
        exp_to = (lat >= T);
        exp_d = exp_to ? 32'd0 : alu_ref(req_inst_num[g], req_rs[g], req_rt[g],
                                         req_const16[g], req_const16_x[g]);
        exp_id = g;
        lastp = g;
        busy = 1'b1;
        hs_n = n;
        taken[g] = 1'b1;
      end
    end
    req_valid = 2'b00;
    resp_ready = 1'b1;
    repeat (T + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares one ALU execution element between two requesters (main issue slot = 0, auxiliary slot = 1). Round-robin arbitration; registers the winner's operands; sequences the element via its active-high start/clear input and `completed` flag. The result, or a timeout error, is returned on a single valid/ready response channel tagged with the requester id. Sits between decode/issue and writeback.

## Interface
- `TIMEOUT_CYCLES`, 15: maximum WAIT cycles before abort. Legal range 2..255.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in [1:0]: per-requester request valid.
- `req_ready` out [1:0]: per-requester grant/accept. At most one bit high.
- `req_pc` in [1:0][31:0]: per-requester pc.
- `req_inst_num` in [1:0][5:0]: per-requester instruction number.
- `req_const16` in [1:0][15:0]: per-requester 16-bit constant.
- `req_const16_x` in [1:0][31:0]: per-requester extended constant.
- `req_rs` in [1:0][31:0]: per-requester rs operand.
- `req_rt` in [1:0][31:0]: per-requester rt operand.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts the result.
- `resp_id` out 1: requester that owns the result.
- `resp_data` out 32: ALU result.
- `resp_timeout` out 1: element did not complete in time; `resp_data` = 0.
- `ee_start` out 1: drives the element's active-high clear input.
- `ee_completed` in 1: element done flag.
- `ee_pc` out 32, `ee_inst_num` out 6, `ee_const16` out 16, `ee_const16_x` out 32, `ee_rs` out 32, `ee_rt` out 32: registered operands to the element.
- `ee_out` in 32: element result.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `ee_start` = 1, so the element is held cleared.
  - Arbiter grants among `req_valid`. When both are valid, grant goes to the requester not served last. Pointer reset value: last = 1, so requester 0 wins first.
  - `req_ready[g]` = `req_valid[g]` & grant (combinational). `req_ready` may depend on `req_valid`. A requester must hold its request fields stable while valid.
  - On handshake: latch fields into `ee_*` regs, latch `id` = g, update the pointer, clear the timeout counter, go to WAIT.
- WAIT:
  - `ee_start` = 0. `req_ready` = 0.
  - The counter increments each cycle.
  - If `ee_completed` = 1: `resp_data` <= `ee_out`, `resp_timeout` <= 0, go to RESP.
  - Else, if counter = `TIMEOUT_CYCLES`-1: `resp_data` <= 0, `resp_timeout` <= 1, go to RESP.
  - When completion and the final count coincide, completion wins.
- RESP:
  - `resp_valid` = 1. `resp_id`, `resp_data`, `resp_timeout` are held stable until `resp_ready`.
  - `ee_start` = 0. `req_ready` = 0.
  - On `resp_ready` go to IDLE. No new request is accepted in the handshake cycle.
- `ee_*` operand registers hold their last values outside IDLE handshakes.
- `inst_num` is not decoded here. Unknown opcodes rely on the element's completion. The team's instruction-number constants are used only by the bench.

## Timing
- Reset asserted, and mid-operation, asynchronously forces:
  - state IDLE, RR pointer = 1, counter 0;
  - `req_ready` 0, `ee_start` 1;
  - `resp_valid` 0, `resp_id` 0, `resp_data` 0, `resp_timeout` 0;
  - all `ee_*` operands 0.
- Any in-flight request is dropped without a response.
- Latency for a 1-cycle element:
  - C0: request handshake.
  - C1: WAIT, `ee_completed` 0 (cleared at C0 edge).
  - C2: WAIT, `ee_completed` 1.
  - C3: `resp_valid` = 1.
- Minimum issue interval is 4 cycles: response handshake in C3, next request accepted in C4.
- Timeout: with no completion, `resp_valid` rises exactly `TIMEOUT_CYCLES`+1 cycles after the request handshake.
- `ee_completed` is ignored outside WAIT. A stale 1 left over from the previous op is masked because the element is cleared throughout IDLE.

## Structure
- Package `exec_ctrl_pkg`:
  - `exec_state_t` enum (IDLE, WAIT, RESP);
  - `req_id_t`;
  - instruction-number localparams (ADD=8, ADDI=9, SUB=10, LUI=11, AND=20, OR=22, XOR=24, NOR=26, ...).
- Sub-module `rr_arbiter2`: inputs valid[1:0], last; outputs grant[1:0], one-hot or zero.
- The FSM, operand registers, timeout counter and response registers live in `alu_issue_arbiter`.

## Test plan
- Req0 ADD (8), rs=5, rt=7, `resp_ready`=1 -> `resp_valid` in C3, `resp_data`=12, `resp_id`=0, `resp_timeout`=0.
- Both valid continuously: req0 SUB 10-3, req1 OR 0xF0|0x0F -> grants alternate 0,1,0. Responses in order: 7 (id 0), 0xFF (id 1).
- Element stub never completes, `TIMEOUT_CYCLES`=15 -> `resp_valid` 16 cycles after handshake, `resp_timeout`=1, `resp_data`=0.
- `resp_ready` low for 5 cycles after `resp_valid` on LUI 0x1234 -> `resp_data`=0x12340000 held stable. `req_ready` stays 0 throughout.
- Reset pulsed low during WAIT -> all outputs at reset values, `ee_start`=1, no response. The next req1 XOR is granted correctly and requester 0 has priority when both are valid.
- Completion on the same cycle as the final timeout count -> `resp_timeout`=0 with `ee_out` captured.
